// File: rtl/ftdi_245sync_device_if.sv
// FT232H 245 sync-FIFO pin bundle plus the host-side byte streams.
// slave = the emulated chip, master = controller and host model.
interface ftdi_245sync_device_if;
  logic       usb_rxf;
  logic       usb_txe;
  logic       usb_oe;
  logic       usb_rd;
  logic       usb_wr;
  logic [7:0] usb_data_in;
  logic [7:0] usb_data_out;
  logic       usb_data_oe;
  logic       dn_valid;
  logic       dn_ready;
  logic [7:0] dn_data;
  logic       up_valid;
  logic       up_ready;
  logic [7:0] up_data;
  logic       proto_err;

  modport slave (
    input  usb_oe, usb_rd, usb_wr, usb_data_in,
    input  dn_valid, dn_data, up_ready,
    output usb_rxf, usb_txe, usb_data_out, usb_data_oe,
    output dn_ready, up_valid, up_data, proto_err
  );

  modport master (
    output usb_oe, usb_rd, usb_wr, usb_data_in,
    output dn_valid, dn_data, up_ready,
    input  usb_rxf, usb_txe, usb_data_out, usb_data_oe,
    input  dn_ready, up_valid, up_data, proto_err
  );
endinterface

// File: rtl/ftdi_245sync_device.sv
// FT232H 245 sync-FIFO device-side emulator for loopback builds.
// Host streams stand in for USB; packet gaps throttle the flags.
module ftdi_245sync_gap #(
  parameter int PKT_BYTES = 512,
  parameter int GAP_CYC   = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic ev,
  output logic gap
);
  typedef enum logic {RUN, GAP} state_t;

  localparam logic [15:0] PKT_LAST = 16'(PKT_BYTES - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

  state_t      state, state_n;
  logic [15:0] bcnt, bcnt_n;
  logic [15:0] gcnt, gcnt_n;

  // state and counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RUN;
      bcnt  <= '0;
      gcnt  <= '0;
    end else begin
      state <= state_n;
      bcnt  <= bcnt_n;
      gcnt  <= gcnt_n;
    end
  end

  // count packet bytes, then hold the flag off for GAP_CYC cycles
  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    gcnt_n  = gcnt;
    unique case (state)
      RUN: begin
        if (ev && PKT_BYTES != 0) begin
          if (bcnt == PKT_LAST) begin
            bcnt_n = '0;
            if (GAP_CYC != 0) begin
              state_n = GAP;
              gcnt_n  = '0;
            end
          end else begin
            bcnt_n = bcnt + 16'd1;
          end
        end
      end
      GAP: begin
        if (gcnt == GAP_LAST) state_n = RUN;
        else gcnt_n = gcnt + 16'd1;
      end
      default: state_n = RUN;
    endcase
  end

  // next-state view so the flag goes high on the edge of the last byte
  assign gap = (state_n == GAP);
endmodule

module ftdi_245sync_device #(
  parameter int DN_AEXP   = 9,
  parameter int UP_AEXP   = 9,
  parameter int PKT_BYTES = 512,
  parameter int GAP_CYC   = 4
) (
  input logic                  usb_clk,
  input logic                  rstn_async,
  ftdi_245sync_device_if.slave bus
);
  localparam int DN_D = 1 << DN_AEXP;
  localparam int UP_D = 1 << UP_AEXP;
  localparam int DN_W = DN_AEXP + 1;
  localparam int UP_W = UP_AEXP + 1;

  logic [7:0]         dn_mem [DN_D];
  logic [DN_AEXP-1:0] dn_wp, dn_rp;
  logic [DN_AEXP:0]   dn_cnt, dn_cnt_n;
  logic               dn_push, dn_pop, dn_gap;

  logic [7:0]         up_mem [UP_D];
  logic [UP_AEXP-1:0] up_wp, up_rp;
  logic [UP_AEXP:0]   up_cnt, up_cnt_n;
  logic               up_push, up_pop, up_gap;

  // transfers qualify against the registered flags the controller sees
  assign dn_push  = bus.dn_valid & bus.dn_ready;
  assign dn_pop   = ~bus.usb_rd & ~bus.usb_rxf & ~bus.usb_oe;
  assign dn_cnt_n = dn_cnt + DN_W'(dn_push) - DN_W'(dn_pop);

  assign up_push  = ~bus.usb_wr & ~bus.usb_txe;
  assign up_pop   = bus.up_valid & bus.up_ready;
  assign up_cnt_n = up_cnt + UP_W'(up_push) - UP_W'(up_pop);

  assign bus.usb_data_out = (|dn_cnt) ? dn_mem[dn_rp] : 8'h00;
  assign bus.up_valid     = |up_cnt;
  assign bus.up_data      = (|up_cnt) ? up_mem[up_rp] : 8'h00;

  ftdi_245sync_gap #(
    .PKT_BYTES (PKT_BYTES),
    .GAP_CYC   (GAP_CYC)
  ) u_dn_gap (
    .clk  (usb_clk),
    .rstn (rstn_async),
    .ev   (dn_pop),
    .gap  (dn_gap)
  );

  ftdi_245sync_gap #(
    .PKT_BYTES (PKT_BYTES),
    .GAP_CYC   (GAP_CYC)
  ) u_up_gap (
    .clk  (usb_clk),
    .rstn (rstn_async),
    .ev   (up_push),
    .gap  (up_gap)
  );

  // buffer storage, contents need no reset
  always_ff @(posedge usb_clk) begin
    if (dn_push) dn_mem[dn_wp] <= bus.dn_data;
    if (up_push) up_mem[up_wp] <= bus.usb_data_in;
  end

  // read-buffer pointers, count and RXF#/ready flags
  always_ff @(posedge usb_clk or negedge rstn_async) begin
    if (!rstn_async) begin
      dn_wp        <= '0;
      dn_rp        <= '0;
      dn_cnt       <= '0;
      bus.dn_ready <= 1'b0;
      bus.usb_rxf  <= 1'b1;
    end else begin
      if (dn_push) dn_wp <= dn_wp + DN_AEXP'(1);
      if (dn_pop)  dn_rp <= dn_rp + DN_AEXP'(1);
      dn_cnt       <= dn_cnt_n;
      bus.dn_ready <= ~dn_cnt_n[DN_AEXP];
      bus.usb_rxf  <= ~((|dn_cnt_n) & ~dn_gap);
    end
  end

  // write-buffer pointers, count and TXE# flag
  always_ff @(posedge usb_clk or negedge rstn_async) begin
    if (!rstn_async) begin
      up_wp       <= '0;
      up_rp       <= '0;
      up_cnt      <= '0;
      bus.usb_txe <= 1'b1;
    end else begin
      if (up_push) up_wp <= up_wp + UP_AEXP'(1);
      if (up_pop)  up_rp <= up_rp + UP_AEXP'(1);
      up_cnt      <= up_cnt_n;
      bus.usb_txe <= ~(~up_cnt_n[UP_AEXP] & ~up_gap);
    end
  end

  // bus turnaround and sticky protocol-violation flag
  always_ff @(posedge usb_clk or negedge rstn_async) begin
    if (!rstn_async) begin
      bus.usb_data_oe <= 1'b0;
      bus.proto_err   <= 1'b0;
    end else begin
      bus.usb_data_oe <= ~bus.usb_oe;
      if ((~bus.usb_oe & ~bus.usb_wr) | (~bus.usb_rd & bus.usb_oe))
        bus.proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ftdi_245sync_device.sv
// Bench for ftdi_245sync_device: scoreboard queues per output
// stream, directed controller/host stimulus, flag timing checks.
module tb_ftdi_245sync_device;
  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  logic [7:0] q_a [$];
  logic [7:0] q_u [$];
  logic [7:0] q_g [$];

  ftdi_245sync_device_if ia ();
  ftdi_245sync_device_if ig ();

  ftdi_245sync_device #(
    .DN_AEXP   (4),
    .UP_AEXP   (4),
    .PKT_BYTES (0),
    .GAP_CYC   (4)
  ) dut_a (
    .usb_clk    (clk),
    .rstn_async (rstn),
    .bus        (ia.slave)
  );

  ftdi_245sync_device #(
    .DN_AEXP   (5),
    .UP_AEXP   (4),
    .PKT_BYTES (8),
    .GAP_CYC   (4)
  ) dut_g (
    .usb_clk    (clk),
    .rstn_async (rstn),
    .bus        (ig.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: compare every byte the DUTs present against the queues
  always @(negedge clk) begin
    if (rstn) begin
      if (!ia.usb_rd && !ia.usb_rxf && !ia.usb_oe) begin
        if (q_a.size() == 0) chk("dn_extra", 1, 0);
        else chk("dn_byte", ia.usb_data_out, q_a.pop_front());
      end
      if (ia.up_valid && ia.up_ready) begin
        if (q_u.size() == 0) chk("up_extra", 1, 0);
        else chk("up_byte", ia.up_data, q_u.pop_front());
      end
      if (!ig.usb_rd && !ig.usb_rxf && !ig.usb_oe) begin
        if (q_g.size() == 0) chk("gap_extra", 1, 0);
        else chk("gap_byte", ig.usb_data_out, q_g.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    rstn = 1'b0;
    ia.usb_oe = 1'b1; ia.usb_rd = 1'b1; ia.usb_wr = 1'b1;
    ia.usb_data_in = 8'h00; ia.dn_valid = 1'b0;
    ia.dn_data = 8'h00; ia.up_ready = 1'b0;
    ig.usb_oe = 1'b1; ig.usb_rd = 1'b1; ig.usb_wr = 1'b1;
    ig.usb_data_in = 8'h00; ig.dn_valid = 1'b0;
    ig.dn_data = 8'h00; ig.up_ready = 1'b0;

    repeat (2) tick();
    chk("rst_rxf", ia.usb_rxf, 1);
    chk("rst_txe", ia.usb_txe, 1);
    chk("rst_oe", ia.usb_data_oe, 0);
    chk("rst_dout", ia.usb_data_out, 0);
    chk("rst_dn_ready", ia.dn_ready, 0);
    chk("rst_up_valid", ia.up_valid, 0);
    chk("rst_perr", ia.proto_err, 0);
    rstn = 1'b1;
    tick();
    chk("idle_txe", ia.usb_txe, 0);
    chk("idle_dn_ready", ia.dn_ready, 1);
    chk("idle_rxf", ia.usb_rxf, 1);

    // DN burst 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      ia.dn_valid = 1'b1;
      ia.dn_data  = 8'(i);
      q_a.push_back(8'(i));
      tick();
    end
    ia.dn_valid = 1'b0;
    chk("dn_full_ready", ia.dn_ready, 0);
    chk("dn_rxf_low", ia.usb_rxf, 0);
    ia.usb_oe = 1'b0;
    tick();
    chk("turn_oe", ia.usb_data_oe, 1);
    ia.usb_rd = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("dn_rxf", ia.usb_rxf, 32'(k == 16));
    end
    ia.usb_rd = 1'b1;
    tick();
    ia.usb_oe = 1'b1;
    tick();
    chk("dn_drained", q_a.size(), 0);
    chk("dn_perr", ia.proto_err, 0);
    chk("dn_ready_back", ia.dn_ready, 1);

    // push and pop on the same edge at count 1
    ia.dn_valid = 1'b1;
    ia.dn_data  = 8'h11;
    q_a.push_back(8'h11);
    tick();
    ia.dn_valid = 1'b0;
    ia.usb_oe = 1'b0;
    tick();
    chk("sim_rxf0", ia.usb_rxf, 0);
    ia.usb_rd   = 1'b0;
    ia.dn_valid = 1'b1;
    ia.dn_data  = 8'hA5;
    q_a.push_back(8'hA5);
    tick();
    ia.dn_valid = 1'b0;
    chk("sim_rxf", ia.usb_rxf, 0);
    chk("sim_head", ia.usb_data_out, 8'hA5);
    tick();
    chk("sim_empty", ia.usb_rxf, 1);
    ia.usb_rd = 1'b1;
    tick();
    ia.usb_oe = 1'b1;
    tick();
    chk("sim_drained", q_a.size(), 0);

    // UP fill with 20 writes into a 16-byte buffer
    ia.up_ready = 1'b0;
    ia.usb_wr   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ia.usb_data_in = 8'(i);
      if (i < 16) q_u.push_back(8'(i));
      tick();
      chk("up_txe", ia.usb_txe, 32'(i >= 15));
    end
    ia.usb_wr   = 1'b1;
    ia.up_ready = 1'b1;
    repeat (18) tick();
    chk("up_empty", ia.up_valid, 0);
    chk("up_drained", q_u.size(), 0);
    chk("up_txe_back", ia.usb_txe, 0);

    // OE# and WR# low together
    ia.usb_data_in = 8'h3C;
    q_u.push_back(8'h3C);
    ia.usb_oe = 1'b0;
    ia.usb_wr = 1'b0;
    tick();
    ia.usb_oe = 1'b1;
    ia.usb_wr = 1'b1;
    chk("perr_set", ia.proto_err, 1);
    repeat (4) tick();
    chk("perr_sticky", ia.proto_err, 1);
    chk("perr_byte", q_u.size(), 0);

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      ia.dn_valid = 1'b1;
      ia.dn_data  = 8'h21 + 8'(i);
      tick();
    end
    ia.dn_valid = 1'b0;
    chk("mrst_pre_rxf", ia.usb_rxf, 0);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("mrst_rxf", ia.usb_rxf, 1);
    chk("mrst_txe", ia.usb_txe, 1);
    chk("mrst_dn_ready", ia.dn_ready, 0);
    chk("mrst_up_valid", ia.up_valid, 0);
    chk("mrst_perr", ia.proto_err, 0);
    chk("mrst_dout", ia.usb_data_out, 0);
    tick();
    rstn = 1'b1;
    repeat (2) tick();
    chk("mrst_empty", ia.usb_rxf, 1);
    chk("mrst_ready", ia.dn_ready, 1);

    // packet gaps: 8 bytes then RXF# high for 4 cycles
    for (int i = 0; i < 24; i++) begin
      ig.dn_valid = 1'b1;
      ig.dn_data  = 8'h40 + 8'(i);
      q_g.push_back(8'h40 + 8'(i));
      tick();
    end
    ig.dn_valid = 1'b0;
    ig.usb_oe = 1'b0;
    tick();
    chk("gap_rxf0", ig.usb_rxf, 0);
    ig.usb_rd = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("gap_rxf", ig.usb_rxf, 32'((k % 12) >= 8));
    end
    ig.usb_rd = 1'b1;
    tick();
    ig.usb_oe = 1'b1;
    tick();
    chk("gap_drained", q_g.size(), 0);
    chk("gap_perr", ig.proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
